// File: rtl/bandai_bank_sequencer.sv
// Bandai mapper bank sequencer: unlocks the mapper, verifies its serial response,
// loads the four boot bank values, then arbitrates bank writes from two requesters.
// Latency: a grant cycle, then cycle A and cycle B on the bus. Backpressure: READYx is
// only offered in OPER while the bus is idle. A requester that drops VALID before READY is forgotten.
//
// Ports:
//   CLK, RSTn                     clock (posedge), async active-low reset
//   SO                            mapper serial response, sampled on posedge
//   REQx_VALID/SEL/DATA/READY     bank-write request handshake, x = 0, 1
//   BUS_ADDR, BUS_DQ_O, BUS_DQ_OE mapper address, data drive value and drive enable
//   BUS_CEn, BUS_WEn, BUS_OEn     mapper strobes, active-low
//   BUSY, ERR                     sequence in progress / sticky unlock failure
module bandai_bank_sequencer #(
  parameter logic [7:0] INIT_LAO  = 8'hFF,
  parameter logic [7:0] INIT_RAM  = 8'hFF,
  parameter logic [7:0] INIT_ROM0 = 8'hFF,
  parameter logic [7:0] INIT_ROM1 = 8'hFF
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SO,
  input  logic       REQ0_VALID,
  input  logic [1:0] REQ0_SEL,
  input  logic [7:0] REQ0_DATA,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [1:0] REQ1_SEL,
  input  logic [7:0] REQ1_DATA,
  output logic       REQ1_READY,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DQ_O,
  output logic       BUS_DQ_OE,
  output logic       BUS_CEn,
  output logic       BUS_WEn,
  output logic       BUS_OEn,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [2:0] {UNLK1, UNLK2, CHECK, INIT, OPER, FAIL} state_t;
  // Write sub-phase: NONE = no write, A = CEn low, B = CEn+WEn low, GAP = idle spacer in INIT.
  typedef enum logic [1:0] {PH_NONE, PH_A, PH_B, PH_GAP} phase_t;

  // Expected mapper response, bit i is compared against SO in check cycle i.
  localparam logic [17:0] CHECK_PAT = 18'h05140;

  // run is low while in reset and rises on the first edge after release, so the
  // state register can sit in UNLK1 during reset while the outputs stay idle.
  logic       run, run_n;
  state_t     state, state_n;
  phase_t     phase, phase_n;
  logic [4:0] bitcnt, bitcnt_n;
  logic [1:0] wsel, wsel_n;
  logic [7:0] wdat, wdat_n;
  logic       ptr, ptr_n;

  logic grant0, grant1, oper_idle;

  function automatic logic [7:0] init_val(input logic [1:0] idx);
    case (idx)
      2'd0:    init_val = INIT_LAO;
      2'd1:    init_val = INIT_RAM;
      2'd2:    init_val = INIT_ROM0;
      default: init_val = INIT_ROM1;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      run    <= 1'b0;
      state  <= UNLK1;
      phase  <= PH_NONE;
      bitcnt <= 5'd0;
      wsel   <= 2'd0;
      wdat   <= 8'h00;
      ptr    <= 1'b0;
    end else begin
      run    <= run_n;
      state  <= state_n;
      phase  <= phase_n;
      bitcnt <= bitcnt_n;
      wsel   <= wsel_n;
      wdat   <= wdat_n;
      ptr    <= ptr_n;
    end
  end

  // Round-robin: ptr names the preferred requester; a lone requester always wins.
  assign grant0    = REQ0_VALID & (~ptr | ~REQ1_VALID);
  assign grant1    = REQ1_VALID & (ptr | ~REQ0_VALID);
  assign oper_idle = run & (state == OPER) & (phase == PH_NONE);

  assign REQ0_READY = oper_idle & grant0;
  assign REQ1_READY = oper_idle & grant1 & ~grant0;

  // Next-state logic
  always_comb begin
    run_n    = run;
    state_n  = state;
    phase_n  = phase;
    bitcnt_n = bitcnt;
    wsel_n   = wsel;
    wdat_n   = wdat;
    ptr_n    = ptr;

    if (!run) begin
      run_n   = 1'b1;
      state_n = UNLK1;
      phase_n = PH_NONE;
    end else begin
      case (state)
        UNLK1: state_n = UNLK2;
        UNLK2: begin
          state_n  = CHECK;
          bitcnt_n = 5'd0;
        end
        CHECK: begin
          if (SO != CHECK_PAT[bitcnt]) begin
            state_n = FAIL;
          end else if (bitcnt == 5'd17) begin
            state_n = INIT;
            phase_n = PH_A;
            wsel_n  = 2'd0;
            wdat_n  = init_val(2'd0);
          end else begin
            bitcnt_n = bitcnt + 5'd1;
          end
        end
        INIT: begin
          // wsel doubles as the boot register index; the last write drops
          // straight into OPER without a trailing gap.
          case (phase)
            PH_A: phase_n = PH_B;
            PH_B: begin
              if (wsel == 2'd3) begin
                state_n = OPER;
                phase_n = PH_NONE;
              end else begin
                phase_n = PH_GAP;
                wsel_n  = wsel + 2'd1;
                wdat_n  = init_val(wsel + 2'd1);
              end
            end
            default: phase_n = PH_A;
          endcase
        end
        OPER: begin
          // After cycle B we return to idle; that idle cycle is the bus gap
          // and is also where the next grant can be offered.
          case (phase)
            PH_NONE: begin
              if (REQ0_READY) begin
                wsel_n  = REQ0_SEL;
                wdat_n  = REQ0_DATA;
                ptr_n   = 1'b1;
                phase_n = PH_A;
              end else if (REQ1_READY) begin
                wsel_n  = REQ1_SEL;
                wdat_n  = REQ1_DATA;
                ptr_n   = 1'b0;
                phase_n = PH_A;
              end
            end
            PH_A:    phase_n = PH_B;
            default: phase_n = PH_NONE;
          endcase
        end
        FAIL:    state_n = FAIL;
        default: state_n = FAIL;
      endcase
    end
  end

  // Bus and status decode; everything is derived from async-reset state so
  // reset idles the bus immediately, even mid-write.
  always_comb begin
    BUS_ADDR  = 8'h00;
    BUS_DQ_O  = 8'h00;
    BUS_DQ_OE = 1'b0;
    BUS_CEn   = 1'b1;
    BUS_WEn   = 1'b1;
    BUS_OEn   = 1'b1;
    BUSY      = 1'b0;
    ERR       = 1'b0;

    if (run) begin
      case (state)
        UNLK1: begin
          BUS_ADDR = 8'h5A;
          BUSY     = 1'b1;
        end
        UNLK2: begin
          BUS_ADDR = 8'hA5;
          BUSY     = 1'b1;
        end
        CHECK: BUSY = 1'b1;
        INIT:  BUSY = 1'b1;
        OPER:  BUSY = (phase != PH_NONE);
        FAIL:  ERR  = 1'b1;
        default: ERR = 1'b1;
      endcase

      if ((state == INIT || state == OPER) && (phase == PH_A || phase == PH_B)) begin
        BUS_ADDR  = {6'b110000, wsel};
        BUS_DQ_O  = wdat;
        BUS_DQ_OE = 1'b1;
        BUS_CEn   = 1'b0;
        BUS_WEn   = (phase != PH_B);
      end
    end
  end

endmodule

// File: tb/tb_bandai_bank_sequencer.sv
module tb_bandai_bank_sequencer;

  logic       CLK = 1'b0;
  logic       RSTn, SO;
  logic       v0, v1;
  logic [1:0] s0, s1;
  logic [7:0] d0, d1;
  logic       rdy0, rdy1;
  logic [7:0] bus_addr, bus_dq;
  logic       bus_oe, bus_cen, bus_wen, bus_oen, busy, err;

  bandai_bank_sequencer dut (
    .CLK(CLK), .RSTn(RSTn), .SO(SO),
    .REQ0_VALID(v0), .REQ0_SEL(s0), .REQ0_DATA(d0), .REQ0_READY(rdy0),
    .REQ1_VALID(v1), .REQ1_SEL(s1), .REQ1_DATA(d1), .REQ1_READY(rdy1),
    .BUS_ADDR(bus_addr), .BUS_DQ_O(bus_dq), .BUS_DQ_OE(bus_oe),
    .BUS_CEn(bus_cen), .BUS_WEn(bus_wen), .BUS_OEn(bus_oen),
    .BUSY(busy), .ERR(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  expq[$];
  logic [17:0] pat = 18'h05140;
  bit   allow_unlk = 1'b0;
  bit   mdl_ptr = 1'b0;
  int   mdl_wait = 0;

  int   cyc = 0;
  int   last_b = -100;
  logic prev_a = 1'b0;
  wr_t  prev_w = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Bus monitor: checks strobe protocol and pops the scoreboard on each cycle B.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (!bus_cen) begin
        chk("wr_oen", bus_oen, 1);
        chk("wr_dq_oe", bus_oe, 1);
        chk("wr_addr_base", bus_addr[7:2], 6'b110000);
        if (bus_wen) begin
          chk("wr_gap", (cyc - last_b) >= 2, 1);
          prev_a <= 1'b1;
          prev_w <= wr_t'{addr: bus_addr, data: bus_dq};
        end else begin
          chk("b_after_a", prev_a, 1);
          chk("b_stable", {bus_addr, bus_dq}, prev_w);
          prev_a <= 1'b0;
          last_b <= cyc;
          if (expq.size() == 0) begin
            chk("unexpected_write", expq.size(), 1);
          end else begin
            wr_t w;
            w = expq.pop_front();
            chk("wr_addr", bus_addr, w.addr);
            chk("wr_data", bus_dq, w.data);
          end
        end
      end else begin
        prev_a <= 1'b0;
        chk("idle_wen", bus_wen, 1);
        chk("idle_oen", bus_oen, 1);
        chk("idle_dq_oe", bus_oe, 0);
        chk("idle_dq", bus_dq, 0);
        if (!allow_unlk) chk("idle_addr", bus_addr, 0);
      end
      chk("ready_exclusive", rdy0 & rdy1, 0);
    end
  end

  // Runs unlock + check from the first edge after reset release.
  // badbit < 0 gives a correct response; otherwise that SO bit is inverted.
  task automatic boot(input int badbit);
    allow_unlk = 1'b1;
    @(posedge CLK); #2;
    chk("unlk1_addr", bus_addr, 8'h5A);
    chk("unlk1_busy", busy, 1);
    chk("unlk1_ready0", rdy0, 0);
    chk("unlk1_ready1", rdy1, 0);
    @(posedge CLK); #2;
    chk("unlk2_addr", bus_addr, 8'hA5);
    chk("unlk2_busy", busy, 1);
    for (int i = 0; i < 18; i++) begin
      @(posedge CLK); #1;
      allow_unlk = 1'b0;
      SO = (i == badbit) ? ~pat[i] : pat[i];
      if (i == 0) chk("check_addr", bus_addr, 0);
      if (badbit < 0 || i <= badbit) begin
        chk("check_busy", busy, 1);
        chk("check_err", err, 0);
      end
      if (badbit >= 0 && i == badbit + 1) begin
        chk("fail_err", err, 1);
        chk("fail_busy", busy, 0);
      end
    end
  endtask

  // One OPER cycle: drive requests, check READY/BUSY against the arbiter model,
  // and push the expected write on a grant.
  task automatic ostep(input logic iv0, input logic [1:0] is0, input logic [7:0] id0,
                       input logic iv1, input logic [1:0] is1, input logic [7:0] id1);
    logic g0, g1;
    @(posedge CLK); #1;
    v0 = iv0; s0 = is0; d0 = id0;
    v1 = iv1; s1 = is1; d1 = id1;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (mdl_wait == 0) begin
      g0 = iv0 && (!mdl_ptr || !iv1);
      g1 = iv1 && !g0;
    end
    chk("ready0", rdy0, g0);
    chk("ready1", rdy1, g1);
    chk("oper_busy", busy, mdl_wait != 0);
    if (g0) begin
      expq.push_back(wr_t'{addr: {6'b110000, is0}, data: id0});
      mdl_ptr  = 1'b1;
      mdl_wait = 2;
    end else if (g1) begin
      expq.push_back(wr_t'{addr: {6'b110000, is1}, data: id1});
      mdl_ptr  = 1'b0;
      mdl_wait = 2;
    end else if (mdl_wait > 0) begin
      mdl_wait--;
    end
  endtask

  initial begin
    int  n;
    bit  done;
    RSTn = 1'b0; SO = 1'b0;
    v0 = 1'b1; s0 = 2'd0; d0 = 8'h00;
    v1 = 1'b1; s1 = 2'd0; d1 = 8'h00;

    // Reset state, with requests pending
    #22;
    chk("rst_addr", bus_addr, 8'h00);
    chk("rst_dq", bus_dq, 8'h00);
    chk("rst_dq_oe", bus_oe, 0);
    chk("rst_cen", bus_cen, 1);
    chk("rst_wen", bus_wen, 1);
    chk("rst_oen", bus_oen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready0", rdy0, 0);
    chk("rst_ready1", rdy1, 0);
    v0 = 1'b0; v1 = 1'b0;

    // Good boot: four default bank writes, OPER at cycle 31
    @(negedge CLK); RSTn = 1'b1;
    for (int k = 0; k < 4; k++) expq.push_back(wr_t'{addr: 8'hC0 + 8'(k), data: 8'hFF});
    boot(-1);
    n = 19;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge CLK); #2;
      n++;
      if (!busy) done = 1'b1;
    end
    chk("oper_entry_cycle", n, 31);
    chk("boot_writes_done", expq.size(), 0);
    chk("boot_err", err, 0);
    mdl_ptr = 1'b0;
    mdl_wait = 0;

    // Both requesters continuously valid: alternates starting with requester 0
    repeat (9) ostep(1, 2'd2, 8'h12, 1, 2'd3, 8'h34);
    repeat (2) ostep(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    chk("alt_writes_done", expq.size(), 0);

    // Only requester 1 valid: every grant goes to it
    repeat (9) ostep(0, 2'd0, 8'h00, 1, 2'd1, 8'h7E);
    repeat (2) ostep(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    chk("req1_writes_done", expq.size(), 0);

    // Requester 0 raises VALID during a write and drops it before READY
    ostep(0, 2'd0, 8'h00, 1, 2'd1, 8'h7E);
    ostep(1, 2'd0, 8'hAA, 0, 2'd0, 8'h00);
    ostep(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    repeat (2) ostep(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);

    // Lone requester 0 wins even when the pointer favours requester 1
    ostep(1, 2'd0, 8'h55, 0, 2'd0, 8'h00);
    repeat (2) ostep(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    ostep(1, 2'd0, 8'h66, 0, 2'd0, 8'h00);
    repeat (3) ostep(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    chk("single_writes_done", expq.size(), 0);

    // Reset asserted during cycle B of a write
    ostep(1, 2'd2, 8'h9C, 0, 2'd0, 8'h00);
    @(posedge CLK); #2;
    chk("midwr_cycle_a", bus_cen, 0);
    @(posedge CLK); #2;
    chk("midwr_b_wen", bus_wen, 0);
    v0 = 1'b1; v1 = 1'b1;
    RSTn = 1'b0;
    #1;
    chk("abort_wen", bus_wen, 1);
    chk("abort_cen", bus_cen, 1);
    chk("abort_dq_oe", bus_oe, 0);
    chk("abort_addr", bus_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_ready0", rdy0, 0);
    chk("aborted_pending", expq.size(), 1);
    expq.delete();

    // Restart with a corrupted response bit: unlock repeats, then FAIL
    @(negedge CLK); RSTn = 1'b1;
    boot(6);
    repeat (10) begin
      @(posedge CLK); #2;
      chk("fail_err_sticky", err, 1);
      chk("fail_ready0", rdy0, 0);
      chk("fail_ready1", rdy1, 0);
      chk("fail_cen", bus_cen, 1);
    end
    chk("fail_no_writes", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
